muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Sequencer between the CPU pipeline and the shared iterative Mult/Div units. It accepts one MULT or DIV request at a time and latches the operands. It pulses the selected unit's start, counts that unit's fixed latency (neither unit has a done flag), then captures the result into architectural HI/LO. Its stall output holds the pipeline while a request is in flight, and it traps divide-by-zero before the divider is started.

Parameters:
DIV_LATENCY, 37, cycles from the div_start edge to the div_hi/div_lo valid edge; capture occurs on the following edge.
MULT_LATENCY, 34, same meaning for the multiplier.
CNT_W, 6, width of the latency counter; must hold max(DIV_LATENCY, MULT_LATENCY).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
op_valid  in  1  request present.
op_code  in  2  0=MULT, 1=DIV, 2=MTHI, 3=MTLO (2/3 only with feature).
op_a  in  32  operand A (dividend / multiplicand / MT data).
op_b  in  32  operand B (divisor / multiplier).
flush  in  1  pipeline flush; aborts the in-flight op.
op_ready  out  1  high only in IDLE.
stall  out  1  op_valid & !op_ready, or state != IDLE.
unit_a  out  32  registered operand A to both units.
unit_b  out  32  registered operand B to both units.
mult_start  out  1  one-cycle start pulse to the multiplier.
div_start  out  1  one-cycle start pulse to the divider.
unit_reset  out  1  active-high reset to both units: !reset | abort pulse.
mult_hi, mult_lo  in  32 each  multiplier results.
div_hi, div_lo  in  32 each  divider results (HI=remainder, LO=quotient).
hi  out  32  architectural HI.
lo  out  32  architectural LO.
div0  out  1  one-cycle pulse on DIV with op_b==0.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; hi=lo=0; unit_a=unit_b=0; all pulses 0; counter 0.
- Handshake: a request is accepted on the edge where op_valid & op_ready. Operands are latched into unit_a/unit_b on that edge and held unchanged until return to IDLE.
- FSM:
  - IDLE:
    - DIV with op_b==0: pulse div0, stay IDLE, hi/lo unchanged, no start issued.
    - DIV otherwise: go START, sel=DIV.
    - MULT: go START, sel=MULT.
  - START (1 cycle): assert the selected start pulse; counter=0; go WAIT.
  - WAIT: counter increments each cycle. When counter == LATENCY-1 of the selected unit, go CAPTURE.
  - CAPTURE (1 cycle): hi/lo <= the selected unit's hi/lo; go IDLE.
- Latency: accept edge to hi/lo update = LATENCY+2 edges. The stall drop coincides with the hi/lo update, so the next instruction sees the new HI/LO.
- hi/lo change only in CAPTURE (or on an MT op); a DIV trapped for divide-by-zero leaves them intact.
- flush in START/WAIT/CAPTURE:
  - Next state is IDLE; hi/lo are not written, including when flush coincides with the CAPTURE edge (flush wins).
  - unit_reset is pulsed for one cycle.
- flush in IDLE: the request is not accepted; no effect.
- op_valid while busy: ignored; stall is high and the pipeline must hold the request.
- Reset mid-operation: everything returns to reset values on the same edge; unit_reset is held high while reset==0.

Optional Feature:
MULDIV_MTHILO_EN:
- Defined:
  - op_code 2 writes hi<=op_a, and op_code 3 writes lo<=op_a, on the accept edge.
  - No FSM excursion; the unit accepts again the next cycle.
- Undefined:
  - op_code 2/3 are accepted and discarded with no state change.
  - op_ready stays 1.

Test Plan:
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> div_start pulses one cycle after accept. At accept+39 edges: lo=0xFFFFFFFD, hi=0xFFFFFFFF. Stall high for exactly 39 cycles.
- MULT op_a=3, op_b=0xFFFFFFFC -> at accept+36 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF4. mult_start only; div_start stays 0.
- DIV op_b=0 with hi=0x11, lo=0x22 preloaded -> div0 pulses one cycle, no start pulse, hi/lo unchanged, op_ready high next cycle.
- Flush in WAIT at counter=10 -> unit_reset pulses one cycle, state IDLE, hi/lo unchanged. A following DIV 100/7 gives lo=14, hi=2.
- Back-to-back: DIV held with op_valid asserted during an in-flight MULT -> DIV accepted on the first IDLE cycle after the MULT capture; both results are correct in order.
- MULDIV_MTHILO_EN: MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi/lo updated on each accept edge, stall never asserted.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the CPU pipeline and the shared iterative
// multiplier / divider. It accepts one MULT or DIV at a time, latches the
// operands, pulses the selected unit's start, and counts that unit's fixed
// latency (the units have no done flag). It then captures the result into
// the architectural HI/LO registers. Divide-by-zero is trapped before the
// divider is started. A flush aborts the in-flight op and resets both units.
//
// Build option: define MULDIV_MTHILO_EN to enable MTHI (op_code 2) and
// MTLO (op_code 3) writes to HI/LO. When it is undefined, op_code 2/3 are
// accepted and discarded.
module muldiv_ctrl #(
  parameter int DIV_LATENCY  = 37,
  parameter int MULT_LATENCY = 34,
  parameter int CNT_W        = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  output logic        unit_reset,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
`ifdef MULDIV_MTHILO_EN
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;
`endif

  // The counter starts at 0 on the first WAIT cycle, so WAIT ends at LATENCY-1.
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LATENCY - 1);

  state_t           state_q, state_d;
  logic             sel_div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_q;
  logic             div0_q;

  logic accept;
  logic start_op;
  logic div_zero;
  logic abort;
  logic cnt_done;
  logic capture;

  // A flush in IDLE blocks acceptance; while busy, a flush aborts the op.
  assign accept   = op_valid & op_ready & ~flush;
  assign start_op = accept & ((op_code == OP_MULT) ||
                              ((op_code == OP_DIV) && (op_b != 32'd0)));
  assign div_zero = accept & (op_code == OP_DIV) & (op_b == 32'd0);
  assign abort    = flush & (state_q != S_IDLE);
  assign cnt_done = sel_div_q ? (cnt_q == DIV_LAST) : (cnt_q == MULT_LAST);
  // A flush on the capture edge wins: HI/LO are not written.
  assign capture  = (state_q == S_CAPTURE) & ~flush;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples the values from before the edge regardless of statement order.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake/pulse outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    op_ready   = (state_q == S_IDLE);
    stall      = (op_valid & ~op_ready) | (state_q != S_IDLE);
    mult_start = (state_q == S_START) & ~sel_div_q;
    div_start  = (state_q == S_START) &  sel_div_q;
    unit_reset = ~reset | abort_q;

    case (state_q)
      S_IDLE:    if (start_op) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (cnt_done) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;
  end

  // Operand latch, unit select, latency counter, HI/LO and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      unit_a    <= '0;
      unit_b    <= '0;
      sel_div_q <= 1'b0;
      cnt_q     <= '0;
      hi        <= '0;
      lo        <= '0;
      div0_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      div0_q  <= div_zero;
      abort_q <= abort;

      // Operands stay frozen from accept until the return to IDLE.
      if (accept) begin
        unit_a <= op_a;
        unit_b <= op_b;
      end

      if (start_op) sel_div_q <= (op_code == OP_DIV);

      if (state_q == S_START)     cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);

      if (capture) begin
        hi <= sel_div_q ? div_hi : mult_hi;
        lo <= sel_div_q ? div_lo : mult_lo;
      end

`ifdef MULDIV_MTHILO_EN
      // Moves to HI/LO complete on the accept edge with no FSM excursion.
      if (accept && (op_code == OP_MTHI)) hi <= op_a;
      if (accept && (op_code == OP_MTLO)) lo <= op_a;
`endif
    end
  end

  assign div0 = div0_q;

endmodule
